// File: rtl/pe_dispatch.sv
// pe_dispatch: issues neuron/weight SRAM beats to a parallel PE and
// collects one 32-bit dot-product per output into a result buffer.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 one-cycle request, sampled in IDLE only
//   cfg_vec_len           beats per output (L), latched at start
//   cfg_out_num           number of outputs (N), latched at start
//   n_rd_en/n_rd_addr     neuron SRAM read port (data 1 cycle later)
//   n_rd_data             neuron SRAM read data
//   w_rd_en/w_rd_addr     weight SRAM read port (data 1 cycle later)
//   w_rd_data             weight SRAM read data
//   pe_neuron/pe_weight   SRAM data passed straight to the PE
//   pe_ctl                bit0 first beat, bit1 last beat
//   pe_vld                beat valid to the PE
//   pe_result/pe_vld_o    PE result and its valid
//   res_we/addr/data      result buffer write port
//   busy                  first issue cycle through final write
//   done                  one-cycle completion pulse
module pe_dispatch #(
   parameter int NADDR_W = 8,
   parameter int WADDR_W = 16,
   parameter int RADDR_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [7:0]         cfg_vec_len,
   input  logic [7:0]         cfg_out_num,
   output logic               n_rd_en,
   output logic [NADDR_W-1:0] n_rd_addr,
   input  logic [511:0]       n_rd_data,
   output logic               w_rd_en,
   output logic [WADDR_W-1:0] w_rd_addr,
   input  logic [511:0]       w_rd_data,
   output logic [511:0]       pe_neuron,
   output logic [511:0]       pe_weight,
   output logic [1:0]         pe_ctl,
   output logic               pe_vld,
   input  logic [31:0]        pe_result,
   input  logic               pe_vld_o,
   output logic               res_we,
   output logic [RADDR_W-1:0] res_addr,
   output logic [31:0]        res_data,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t state;

   logic [7:0]         len_q;
   logic [7:0]         num_q;
   logic [7:0]         beat_q;
   logic [7:0]         out_q;
   logic [7:0]         beat_nx;
   logic [7:0]         out_nx;
   logic [15:0]        w_nx;
   logic [7:0]         wr_cnt;
   logic [RADDR_W-1:0] r_q;
   logic               rd_en_q;
   logic               cfg_ok;
   logic               last_beat;
   logic               last_issue;
   logic               final_wr;

   // SRAM data goes straight to the PE; metadata is delayed to match.
   assign pe_neuron = n_rd_data;
   assign pe_weight = w_rd_data;

   assign n_rd_en = rd_en_q;
   assign w_rd_en = rd_en_q;

   assign cfg_ok     = (|cfg_vec_len) && (|cfg_out_num);
   assign last_beat  = (beat_q == len_q - 8'd1);
   assign last_issue = last_beat && (out_q == num_q - 8'd1);

   // wr_cnt already counts the write currently on res_we.
   assign final_wr = res_we && (wr_cnt == num_q);

   // Next beat/output pair; weight address is o*L+b of that pair.
   always_comb begin
      beat_nx = beat_q + 8'd1;
      out_nx  = out_q;
      if (last_beat) begin
         beat_nx = 8'd0;
         out_nx  = out_q + 8'd1;
      end
      w_nx = ({8'd0, out_nx} * {8'd0, len_q}) + {8'd0, beat_nx};
   end

   // Sequencer: issue, drain, completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         len_q     <= 8'd0;
         num_q     <= 8'd0;
         beat_q    <= 8'd0;
         out_q     <= 8'd0;
         rd_en_q   <= 1'b0;
         n_rd_addr <= '0;
         w_rd_addr <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (cfg_ok) begin
                     len_q     <= cfg_vec_len;
                     num_q     <= cfg_out_num;
                     beat_q    <= 8'd0;
                     out_q     <= 8'd0;
                     rd_en_q   <= 1'b1;
                     n_rd_addr <= '0;
                     w_rd_addr <= '0;
                     busy      <= 1'b1;
                     state     <= RUN;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            RUN: begin
               if (last_issue) begin
                  rd_en_q <= 1'b0;
                  state   <= DRAIN;
               end else begin
                  beat_q    <= beat_nx;
                  out_q     <= out_nx;
                  n_rd_addr <= NADDR_W'(beat_nx);
                  w_rd_addr <= WADDR_W'(w_nx);
               end
            end
            DRAIN: begin
               if (final_wr) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // First/last flags travel one cycle behind the read request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_vld <= 1'b0;
         pe_ctl <= 2'b00;
      end else begin
         pe_vld <= rd_en_q;
         pe_ctl <= {rd_en_q && last_beat,
                    rd_en_q && (beat_q == 8'd0)};
      end
   end

   // Result capture; PE valids outside a run are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_we   <= 1'b0;
         res_addr <= '0;
         res_data <= 32'd0;
         r_q      <= '0;
         wr_cnt   <= 8'd0;
      end else begin
         res_we <= 1'b0;
         if (state == IDLE) begin
            r_q    <= '0;
            wr_cnt <= 8'd0;
         end else if (busy && pe_vld_o) begin
            res_we   <= 1'b1;
            res_data <= pe_result;
            res_addr <= r_q;
            r_q      <= r_q + RADDR_W'(1);
            wr_cnt   <= wr_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_pe_dispatch.sv
// tb_pe_dispatch: scoreboard bench for pe_dispatch with SRAM and
// ideal parallel_pe models.
module tb_pe_dispatch;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [7:0]   cfg_vec_len;
   logic [7:0]   cfg_out_num;
   logic         n_rd_en;
   logic [7:0]   n_rd_addr;
   logic [511:0] n_rd_data;
   logic         w_rd_en;
   logic [15:0]  w_rd_addr;
   logic [511:0] w_rd_data;
   logic [511:0] pe_neuron;
   logic [511:0] pe_weight;
   logic [1:0]   pe_ctl;
   logic         pe_vld;
   logic [31:0]  pe_result;
   logic         pe_vld_o;
   logic         res_we;
   logic [7:0]   res_addr;
   logic [31:0]  res_data;
   logic         busy;
   logic         done;

   logic         pe_vld_m;
   logic         inj;
   logic [31:0]  acc;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int c0 = 0;
   int mrel;
   bit mon_on = 1'b0;
   int mon_nl = 0;
   int vld_cnt, vld_first, vld_last;
   int done_cnt, done_rel, busy_bad;
   int done_total = 0;
   int we_total = 0;

   int na_q[$];
   int wa_q[$];
   int ctl_q[$];
   int we_q[$];
   int ea_q[$];
   logic [31:0] ed_q[$];

   pe_dispatch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .cfg_vec_len (cfg_vec_len),
      .cfg_out_num (cfg_out_num),
      .n_rd_en     (n_rd_en),
      .n_rd_addr   (n_rd_addr),
      .n_rd_data   (n_rd_data),
      .w_rd_en     (w_rd_en),
      .w_rd_addr   (w_rd_addr),
      .w_rd_data   (w_rd_data),
      .pe_neuron   (pe_neuron),
      .pe_weight   (pe_weight),
      .pe_ctl      (pe_ctl),
      .pe_vld      (pe_vld),
      .pe_result   (pe_result),
      .pe_vld_o    (pe_vld_o),
      .res_we      (res_we),
      .res_addr    (res_addr),
      .res_data    (res_data),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [511:0] nbeat(input int a);
      logic [511:0] r;
      for (int i = 0; i < 32; i++)
         r[i*16 +: 16] = 16'((a * 7 + i * 3 + 1) % 256);
      return r;
   endfunction

   function automatic logic [511:0] wbeat(input int a);
      logic [511:0] r;
      for (int i = 0; i < 32; i++)
         r[i*16 +: 16] = 16'((a * 5 + i * 11 + 2) % 256);
      return r;
   endfunction

   function automatic logic [31:0] dot(input logic [511:0] x,
                                       input logic [511:0] y);
      logic [31:0] s;
      s = 32'd0;
      for (int i = 0; i < 32; i++)
         s = s + {16'd0, x[i*16 +: 16]} * {16'd0, y[i*16 +: 16]};
      return s;
   endfunction

   // SRAMs with one-cycle read latency
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_rd_data <= '0;
         w_rd_data <= '0;
      end else begin
         if (n_rd_en) n_rd_data <= nbeat(int'(n_rd_addr));
         if (w_rd_en) w_rd_data <= wbeat(int'(w_rd_addr));
      end
   end

   // Ideal PE: accumulate, report the sum the cycle after a last beat
   always @(posedge clk or negedge rst_n) begin
      logic [31:0] nacc;
      if (!rst_n) begin
         acc       <= 32'd0;
         pe_vld_m  <= 1'b0;
         pe_result <= 32'd0;
      end else begin
         pe_vld_m <= 1'b0;
         if (pe_vld) begin
            nacc = dot(pe_neuron, pe_weight);
            if (!pe_ctl[0]) nacc = nacc + acc;
            acc <= nacc;
            if (pe_ctl[1]) begin
               pe_vld_m  <= 1'b1;
               pe_result <= nacc;
            end
         end
      end
   end

   assign pe_vld_o = pe_vld_m | inj;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Monitor: logs beats and writes, scoreboards every result write
   always @(negedge clk) begin
      if (done) done_total++;
      if (res_we) we_total++;
      if (mon_on) begin
         mrel = cyc - c0;
         if (n_rd_en) begin
            na_q.push_back(int'(n_rd_addr));
            wa_q.push_back(int'(w_rd_addr));
         end
         if (pe_vld) begin
            if (vld_cnt == 0) vld_first = mrel;
            vld_last = mrel;
            vld_cnt++;
            ctl_q.push_back(int'(pe_ctl));
         end
         if (res_we) begin
            we_q.push_back(mrel);
            if (ea_q.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               chk("res_addr", res_addr, ea_q.pop_front());
               chk("res_data", res_data, ed_q.pop_front());
            end
         end
         if (done) begin
            done_cnt++;
            done_rel = mrel;
         end
         if (busy !== (mon_nl > 0 && mrel >= 1 && mrel <= mon_nl + 3))
            busy_bad++;
      end
   end

   task automatic run(input int l, input int n, input bit disturb);
      int nl;
      int ne;
      int guard;
      logic [31:0] g;
      nl = (l == 0 || n == 0) ? 0 : l * n;
      ne = (nl == 0) ? 0 : n;
      for (int o = 0; o < ne; o++) begin
         g = 32'd0;
         for (int b = 0; b < l; b++)
            g = g + dot(nbeat(b), wbeat(o * l + b));
         ea_q.push_back(o);
         ed_q.push_back(g);
      end
      na_q.delete();
      wa_q.delete();
      ctl_q.delete();
      we_q.delete();
      vld_cnt = 0;
      vld_first = -1;
      vld_last = -1;
      done_cnt = 0;
      done_rel = -1;
      busy_bad = 0;
      mon_nl = nl;
      cfg_vec_len = 8'(l);
      cfg_out_num = 8'(n);
      start = 1'b1;
      c0 = cyc;
      mon_on = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      guard = 0;
      while (done_cnt == 0 && guard < 4000) begin
         if (disturb && (cyc - c0 == 3 || cyc - c0 == 10)) begin
            start = 1'b1;
            cfg_vec_len = 8'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         guard++;
      end
      start = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      mon_on = 1'b0;
      chk("timeout", guard >= 4000, 0);
      chk("done_cyc", done_rel, (nl == 0) ? 1 : nl + 4);
      chk("done_cnt", done_cnt, 1);
      chk("vld_cnt", vld_cnt, nl);
      if (nl > 0) begin
         chk("vld_first", vld_first, 2);
         chk("vld_last", vld_last, nl + 1);
      end
      chk("rd_cnt", na_q.size(), nl);
      for (int j = 0; j < na_q.size(); j++) begin
         chk("n_addr", na_q[j], j % l);
         chk("w_addr", wa_q[j], j);
      end
      chk("ctl_cnt", ctl_q.size(), nl);
      for (int j = 0; j < ctl_q.size(); j++)
         chk("pe_ctl", ctl_q[j],
             ((j % l == l - 1) ? 2 : 0) | ((j % l == 0) ? 1 : 0));
      chk("we_cnt", we_q.size(), ne);
      for (int k = 0; k < we_q.size(); k++)
         chk("we_cyc", we_q[k], (k + 1) * l + 3);
      chk("sb_left", ea_q.size(), 0);
      chk("busy", busy_bad, 0);
      ea_q.delete();
      ed_q.delete();
   endtask

   function automatic logic [12:0] outs();
      return {n_rd_en, w_rd_en, |n_rd_addr, |w_rd_addr, |pe_neuron,
              |pe_weight, |pe_ctl, pe_vld, res_we, |res_addr,
              |res_data, busy, done};
   endfunction

   initial begin
      int d0;
      int w0;
      rst_n = 1'b0;
      start = 1'b0;
      inj = 1'b0;
      cfg_vec_len = 8'd0;
      cfg_out_num = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", outs(), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run(4, 3, 1'b0);
      run(1, 5, 1'b0);
      run(0, 7, 1'b0);
      run(3, 0, 1'b0);
      run(8, 2, 1'b1);

      // Reset in the middle of an L=4, N=4 run
      d0 = done_total;
      w0 = we_total;
      cfg_vec_len = 8'd4;
      cfg_out_num = 8'd4;
      start = 1'b1;
      c0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_outs0", outs(), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_outs1", outs(), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk("midrst_done", done_total - d0, 0);
      chk("midrst_we", we_total - w0, 0);
      run(2, 1, 1'b0);

      // Stray PE valid while idle
      w0 = we_total;
      inj = 1'b1;
      @(posedge clk); #1;
      inj = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("idle_we", we_total - w0, 0);
      run(3, 2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
